// File: rtl/traffic_cfg_sequencer.sv
// traffic_cfg_sequencer
// Replays a small local table of traffic-light configuration writes onto the
// shared configuration bus (traffic_sel/color_sel/start_color/input_time with
// an inst_send strobe), spacing each write with fixed setup and hold windows.
// It can optionally finish with an inst_go strobe so that the lights start
// running without manual switch and button programming.
//
// Strobe timing: inst_send, inst_go and done come from registers. They are
// masked by abort in the cycle abort is high. As a result, a SEND or GO cycle
// that is being aborted never reaches the lights.
//
// Debug: state_dbg exposes the FSM state encoding:
//   0 = IDLE, 1 = SETUP, 2 = SEND, 3 = HOLD, 4 = GO, 5 = DONE.
module traffic_cfg_sequencer #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter bit AUTO_GO   = 1'b1
) (
    input  logic          clk,
    input  logic          arst_i,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   num_entries,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_addr,
    input  logic [8:0]    tbl_wdata,
    output logic [1:0]    traffic_sel,
    output logic          color_sel,
    output logic          start_color,
    output logic [4:0]    input_time,
    output logic          inst_send,
    output logic          inst_go,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SEND  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GO    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [AW:0] DEPTH_N  = (AW+1)'(DEPTH);
    localparam logic [7:0]  SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t      state;
    logic [AW:0] ptr;      // index of the entry currently on the bus
    logic [AW:0] n_last;   // index of the last entry of this run
    logic [7:0]  cnt;      // remaining cycles in SETUP or HOLD, minus one
    logic        send_q;
    logic        go_q;
    logic        done_q;

    // Table storage. It is not reset, so it survives reset.
    logic [8:0]  tbl [DEPTH];

    // Next entry in the sequence and the table word for it.
    logic [AW:0] ptr_nxt;
    logic [8:0]  entry_nxt;
    // Clamped run length for a start request in the current cycle.
    logic [AW:0] n_eff;
    logic        n_clamped;

    // Next-entry pointer, the table read for it, and clamping of the run length.
    always_comb begin
        ptr_nxt   = ptr + 1'b1;
        entry_nxt = tbl[ptr_nxt[AW-1:0]];
        n_clamped = (num_entries > DEPTH_N);
        n_eff     = n_clamped ? DEPTH_N : num_entries;
    end

    // Table writes are accepted only while idle. Writes in other states are flagged through err.
    always_ff @(posedge clk) begin
        if (tbl_we && (state == ST_IDLE)) begin
            tbl[tbl_addr] <= tbl_wdata;
        end
    end

    // Playback FSM. It has registered bus fields, strobes and status flags.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            n_last      <= '0;
            cnt         <= '0;
            send_q      <= 1'b0;
            go_q        <= 1'b0;
            done_q      <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            traffic_sel <= '0;
            color_sel   <= 1'b0;
            start_color <= 1'b0;
            input_time  <= '0;
        end else begin
            // Strobes are single-cycle unless a state below raises them again.
            send_q <= 1'b0;
            go_q   <= 1'b0;
            done_q <= 1'b0;

            if (tbl_we && (state != ST_IDLE)) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        err    <= n_clamped;
                        ptr    <= '0;
                        n_last <= n_eff - 1'b1;
                        if (n_eff == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state       <= ST_SETUP;
                            busy        <= 1'b1;
                            cnt         <= SETUP_LD;
                            traffic_sel <= tbl[0][8:7];
                            color_sel   <= tbl[0][6];
                            start_color <= tbl[0][5];
                            input_time  <= tbl[0][4:0];
                        end
                    end
                end

                ST_SETUP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state  <= ST_SEND;
                        send_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_SEND: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_HOLD;
                        cnt   <= HOLD_LD;
                    end
                end

                ST_HOLD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (ptr == n_last) begin
                        if (AUTO_GO) begin
                            state <= ST_GO;
                            go_q  <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            busy   <= 1'b0;
                        end
                    end else begin
                        state       <= ST_SETUP;
                        ptr         <= ptr_nxt;
                        cnt         <= SETUP_LD;
                        traffic_sel <= entry_nxt[8:7];
                        color_sel   <= entry_nxt[6];
                        start_color <= entry_nxt[5];
                        input_time  <= entry_nxt[4:0];
                    end
                end

                ST_GO: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Strobe outputs. Each is masked by abort so that an aborted cycle emits nothing.
    always_comb begin
        inst_send = send_q && !abort;
        inst_go   = go_q && !abort;
        done      = done_q && !abort;
        state_dbg = state;
    end

endmodule
